// File: rtl/mac_reg_arbiter.sv
// mac_reg_arbiter: shares one MAC register control port among NUM_REQ requesters.
// Round-robin grant, one access in flight, MAC busy/wait hidden from requesters,
// watchdog abort of hung accesses.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/write/addr/wdata   per-requester command (addr 8b, wdata 32b per slot)
//   req_ready                    1-cycle pulse, command accepted
//   rsp_valid                    1-cycle pulse, access finished
//   rsp_err, rsp_rdata           completion status / read data (held until next completion)
//   mac_reg_addr/din/wr/rd       to MAC register port
//   mac_reg_busy, mac_reg_dout   from MAC register port
//   grant_id, arb_busy           current/last grantee, FSM not idle
module mac_reg_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [8*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_err,
  output logic [31:0]             rsp_rdata,
  output logic [7:0]              mac_reg_addr,
  output logic [31:0]             mac_reg_din,
  output logic                    mac_reg_wr,
  output logic                    mac_reg_rd,
  input  logic                    mac_reg_busy,
  input  logic [31:0]             mac_reg_dout,
  output logic [2:0]              grant_id,
  output logic                    arb_busy
);

  // Counter only has to reach TIMEOUT_CYC-1: the abort fires on the edge that
  // would take it to TIMEOUT_CYC.
  localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit            TO_EN    = (TIMEOUT_CYC > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_ptr, w_ptr_nxt;
  logic [2:0]          r_gnt, w_gnt_nxt;
  logic                r_write, w_write_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [7:0]          r_addr, w_addr_nxt;
  logic [31:0]         r_din, w_din_nxt;
  logic                r_wr, w_wr_nxt;
  logic                r_rd, w_rd_nxt;
  logic                r_err, w_err_nxt;
  logic [31:0]         r_rdata, w_rdata_nxt;
  logic [NUM_REQ-1:0]  r_ready, w_ready_nxt;
  logic [NUM_REQ-1:0]  r_rsp, w_rsp_nxt;
  logic                w_found;
  logic [2:0]          w_sel;
  logic                w_done;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_write_nxt = r_write;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_wr_nxt    = r_wr;
    w_rd_nxt    = r_rd;
    w_err_nxt   = r_err;
    w_rdata_nxt = r_rdata;
    w_ready_nxt = '0;
    w_rsp_nxt   = '0;
    w_done      = 1'b0;
    w_found     = 1'b0;
    w_sel       = '0;

    // Round-robin: first pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1
    // (anything at or above ptr was already taken by the first pass).
    for (int i = 0; i < NUM_REQ; i++)
      if (!w_found && req_valid[i] && (3'(i) >= r_ptr)) begin
        w_found = 1'b1;
        w_sel   = 3'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_sel   = 3'(i);
      end

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          for (int i = 0; i < NUM_REQ; i++)
            if (w_sel == 3'(i)) begin
              w_addr_nxt     = req_addr[8*i +: 8];
              w_din_nxt      = req_wdata[32*i +: 32];
              w_write_nxt    = req_write[i];
              w_ready_nxt[i] = 1'b1;
            end
          w_wr_nxt    = w_write_nxt;
          w_rd_nxt    = !w_write_nxt;
          w_gnt_nxt   = w_sel;
          w_ptr_nxt   = (w_sel == 3'(NUM_REQ-1)) ? 3'd0 : w_sel + 3'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!mac_reg_busy) begin
          w_done      = 1'b1;
          w_err_nxt   = 1'b0;
          w_rdata_nxt = r_write ? 32'h0 : mac_reg_dout;
        end else if (TO_EN && (r_cnt == CNT_LAST)) begin
          w_done      = 1'b1;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = 32'h0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
        if (w_done) begin
          w_wr_nxt    = 1'b0;
          w_rd_nxt    = 1'b0;
          w_state_nxt = S_RESP;
          for (int i = 0; i < NUM_REQ; i++)
            if (r_gnt == 3'(i)) w_rsp_nxt[i] = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_ready <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_write <= w_write_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      r_ready <= w_ready_nxt;
      r_rsp   <= w_rsp_nxt;
    end
  end

  assign req_ready    = r_ready;
  assign rsp_valid    = r_rsp;
  assign rsp_err      = r_err;
  assign rsp_rdata    = r_rdata;
  assign mac_reg_addr = r_addr;
  assign mac_reg_din  = r_din;
  assign mac_reg_wr   = r_wr;
  assign mac_reg_rd   = r_rd;
  assign grant_id     = r_gnt;
  assign arb_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mac_reg_arbiter.sv
module tb_mac_reg_arbiter;
  localparam int NR = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_write = '0;
  logic [8*NR-1:0] req_addr = '0;
  logic [32*NR-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;
  logic [7:0]      mac_reg_addr;
  logic [31:0]     mac_reg_din;
  logic            mac_reg_wr, mac_reg_rd;
  logic            mac_reg_busy = 1'b0;
  logic [31:0]     mac_reg_dout = '0;
  logic [2:0]      grant_id;
  logic            arb_busy;

  mac_reg_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mac_reg_addr(mac_reg_addr), .mac_reg_din(mac_reg_din),
    .mac_reg_wr(mac_reg_wr), .mac_reg_rd(mac_reg_rd),
    .mac_reg_busy(mac_reg_busy), .mac_reg_dout(mac_reg_dout),
    .grant_id(grant_id), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [NR-1:0] mon_oh;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every rsp_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b with nothing pending", rsp_valid);
      end else begin
        mon_e  = sb.pop_front();
        mon_oh = NR'(1) << mon_e.id;
        if (rsp_valid !== mon_oh || rsp_err !== mon_e.err || rsp_rdata !== mon_e.rdata) begin
          errors++;
          $display("FAIL rsp: got valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h",
                   rsp_valid, rsp_err, rsp_rdata, mon_oh, mon_e.err, mon_e.rdata);
        end
      end
    end
  end

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic set_req(input int id, input logic wr, input logic [7:0] a, input logic [31:0] d);
    req_valid[id] = 1'b1;
    req_write[id] = wr;
    req_addr[8*id +: 8] = a;
    req_wdata[32*id +: 32] = d;
  endtask

  // Wait (bounded) for a req_ready bit inside mask; ok=0 on expiry.
  task automatic wait_ready(input logic [NR-1:0] mask, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if ((req_ready & mask) != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mac_reg_wr, mac_reg_rd, arb_busy} !== '0) begin
      errors++; $display("FAIL reset_ctl: got %b want 0", {req_ready, rsp_valid, rsp_err, mac_reg_wr, mac_reg_rd, arb_busy});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    checks++;
    if ({mac_reg_addr, mac_reg_din} !== 40'h0) begin
      errors++; $display("FAIL reset_mac: got addr=%h din=%h want 0", mac_reg_addr, mac_reg_din);
    end
    checks++;
    if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    reset_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_write;
    mac_reg_busy = 1'b0;
    set_req(0, 1'b1, 8'h02, 32'h00800223);
    sb.push_back('{id: 0, err: 1'b0, rdata: 32'h0});
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    checks++;
    if ({mac_reg_wr, mac_reg_rd} !== 2'b10 || mac_reg_addr !== 8'h02 || mac_reg_din !== 32'h00800223) begin
      errors++; $display("FAIL wr_strobe: got wr=%b rd=%b addr=%h din=%h want 1 0 02 00800223",
                         mac_reg_wr, mac_reg_rd, mac_reg_addr, mac_reg_din);
    end
    checks++;
    if (grant_id !== 3'd0 || arb_busy !== 1'b1) begin
      errors++; $display("FAIL wr_gid: got gid=%0d busy=%b want 0 1", grant_id, arb_busy);
    end
    req_valid[0] = 1'b0;
    m_ptr = 1;
    @(negedge clk);
    checks++;
    if ({mac_reg_wr, mac_reg_rd, req_ready} !== 4'b0 || rsp_valid !== 2'b01) begin
      errors++; $display("FAIL wr_resp_cycle: got wr=%b rd=%b ready=%b rsp=%b want 0 0 00 01",
                         mac_reg_wr, mac_reg_rd, req_ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++; $display("FAIL wr_idle: got busy=%b rsp=%b want 0 00", arb_busy, rsp_valid);
    end
  endtask

  task automatic test_read_wait;
    int n;
    n = 0;
    mac_reg_busy = 1'b1;
    mac_reg_dout = 32'h0;
    set_req(1, 1'b0, 8'h03, 32'h0);
    sb.push_back('{id: 1, err: 1'b0, rdata: 32'h56341202});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[1]) req_valid[1] = 1'b0;
      checks++;
      if (req_ready[0]) begin errors++; $display("FAIL rd_ready0: got ready0=1 want 0 outside IDLE"); end
      if (!mac_reg_rd && n > 0) break;
      if (mac_reg_rd) begin
        n++;
        checks++;
        if (mac_reg_addr !== 8'h03) begin errors++; $display("FAIL rd_addr_hold: got %h want 03", mac_reg_addr); end
      end
      // a request that appears and vanishes during ACCESS must never be served
      if (n == 2) set_req(0, 1'b1, 8'h07, 32'h77);
      if (n == 3) req_valid[0] = 1'b0;
      if (n == 4) begin mac_reg_busy = 1'b0; mac_reg_dout = 32'h56341202; end
    end
    m_ptr = 0;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL rd_strobe_len: got %0d want 4", n); end
    mac_reg_dout = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_rdata !== 32'h56341202 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL rd_hold: got rdata=%h busy=%b want 56341202 0", rsp_rdata, arb_busy);
    end
  endtask

  task automatic test_contention;
    bit ok;
    int exp_id, last;
    logic [NR-1:0] oh;
    last = 0;
    mac_reg_busy = 1'b0;
    mac_reg_dout = 32'hCAFE0001;
    set_req(0, 1'b1, 8'h20, 32'h11111111);
    set_req(1, 1'b0, 8'h21, 32'h0);
    for (int k = 0; k < 6; k++) begin
      wait_ready(2'b11, ok);
      exp_id = rr_pick(req_valid, m_ptr);
      oh = NR'(1) << exp_id;
      checks++;
      if (!ok || req_ready !== oh) begin
        errors++; $display("FAIL cont_grant%0d: got ready=%b want %b", k, req_ready, oh);
      end
      checks++;
      if (grant_id !== 3'(exp_id)) begin errors++; $display("FAIL cont_gid%0d: got %0d want %0d", k, grant_id, exp_id); end
      sb.push_back('{id: exp_id, err: 1'b0, rdata: req_write[exp_id] ? 32'h0 : 32'hCAFE0001});
      if (k > 0) begin
        checks++;
        if (cyc - last !== 3) begin errors++; $display("FAIL cont_spacing%0d: got %0d want 3", k, cyc - last); end
      end
      last = cyc;
      m_ptr = (exp_id + 1) % NR;
      if (k == 5) req_valid = '0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    bit ok;
    n = 0;
    mac_reg_busy = 1'b1;
    set_req(0, 1'b0, 8'h10, 32'h0);
    sb.push_back('{id: 0, err: 1'b1, rdata: 32'h0});
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready[0]) req_valid[0] = 1'b0;
      if (!mac_reg_rd && n > 0) break;
      if (mac_reg_rd) n++;
    end
    m_ptr = 1;
    checks++;
    if (n !== TO) begin errors++; $display("FAIL to_strobe_len: got %0d want %0d", n, TO); end
    @(negedge clk);
    mac_reg_busy = 1'b0;
    set_req(1, 1'b1, 8'h11, 32'hDEAD0011);
    wait_ready(2'b10, ok);
    checks++;
    if (!ok || mac_reg_wr !== 1'b1 || mac_reg_addr !== 8'h11) begin
      errors++; $display("FAIL to_next_grant: got ok=%0d wr=%b addr=%h want 1 1 11", ok, mac_reg_wr, mac_reg_addr);
    end
    sb.push_back('{id: 1, err: 1'b0, rdata: 32'h0});
    req_valid[1] = 1'b0;
    m_ptr = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int exp_id;
    mac_reg_busy = 1'b1;
    set_req(0, 1'b1, 8'h05, 32'h5);
    wait_ready(2'b01, ok);
    req_valid[0] = 1'b0;
    checks++;
    if (!ok || mac_reg_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_start: got ok=%0d wr=%b want 1 1", ok, mac_reg_wr); end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mac_reg_wr, mac_reg_rd, arb_busy, req_ready} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_async: got wr=%b rd=%b busy=%b ready=%b want 0",
                         mac_reg_wr, mac_reg_rd, arb_busy, req_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mac_reg_busy = 1'b0;
    mac_reg_dout = 32'h0BADF00D;
    m_ptr = 0;
    set_req(0, 1'b1, 8'h06, 32'h66);
    set_req(1, 1'b0, 8'h07, 32'h0);
    for (int k = 0; k < 2; k++) begin
      exp_id = rr_pick(req_valid, m_ptr);
      wait_ready(2'b11, ok);
      checks++;
      if (!ok || req_ready !== (NR'(1) << exp_id)) begin
        errors++; $display("FAIL rst_mid_grant%0d: got ready=%b want id %0d", k, req_ready, exp_id);
      end
      sb.push_back('{id: exp_id, err: 1'b0, rdata: req_write[exp_id] ? 32'h0 : 32'h0BADF00D});
      req_valid[exp_id] = 1'b0;
      m_ptr = (exp_id + 1) % NR;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_wait;
    test_contention;
    test_timeout;
    test_reset_mid;
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
